// File: rtl/merger_sink_pkg.sv
// Shared constants, word/key types and key extraction for the merger sink.
package merger_sink_pkg;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int DEPTH_MIN      = 4;
  localparam int READY_SLACK    = 3;

  typedef logic [2*DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [DATA_WIDTH_DEF-1:0]   key_t;

  // key is the low record (rec0) of a {rec1, rec0} word
  function automatic key_t key_of(input word_t w);
    return w[DATA_WIDTH_DEF-1:0];
  endfunction
endpackage

// File: rtl/merger_sink_if.sv
// Valid/ready word stream; the merger side uses valid as its write strobe.
interface merger_sink_if #(parameter int W = 256);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/merger_sink_buf.sv
// Show-ahead circular buffer; a pop is resolved before the push so a full
// buffer can accept a word in the same cycle it releases one.
module merger_sink_buf #(
  parameter  int W     = 256,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count_next,
  output logic          full,
  output logic          empty,
  output logic          push,
  output logic          pop
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop        = pop_req && !empty;
  assign push       = push_req && (!full || pop);
  assign count_next = count + CW'(push) - CW'(pop);
  assign rdata      = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/merger_sink.sv
// Merger output sink: buffered forwarding, run-length tracking on zero-key
// terminators, overflow flag. Define MERGER_SINK_ORDER_CHECK_EN for key-order checking.
module merger_sink
  import merger_sink_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  merger_sink_if.slave     in_if,
  merger_sink_if.master    out_if,
  output logic             o_run_done,
  output logic [CNT_W-1:0] o_run_len,
  output logic             o_overflow,
  output logic             o_order_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         count_next;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] key;
  logic                  is_term;
  logic [CNT_W-1:0]      run_cnt;

  merger_sink_buf #(.W(2*DATA_WIDTH), .DEPTH(DEPTH)) u_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .push_req   (in_if.valid),
    .pop_req    (out_if.ready),
    .wdata      (in_if.data),
    .rdata      (out_if.data),
    .count_next (count_next),
    .full       (full),
    .empty      (empty),
    .push       (push),
    .pop        (pop)
  );

  assign out_if.valid = !empty;
  assign key          = in_if.data[DATA_WIDTH-1:0];
  assign is_term      = (key == '0);

  // merger sees ready a cycle late, so leave room for two in-flight words
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) in_if.ready <= 1'b0;
    else          in_if.ready <= (count_next <= CW'(DEPTH - READY_SLACK));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        o_overflow <= 1'b0;
    else if (in_if.valid && full && !pop) o_overflow <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_cnt    <= '0;
      o_run_len  <= '0;
      o_run_done <= 1'b0;
    end else begin
      o_run_done <= 1'b0;
      if (push) begin
        if (is_term) begin
          o_run_len  <= run_cnt;
          o_run_done <= 1'b1;
          run_cnt    <= '0;
        end else if (run_cnt != '1) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef MERGER_SINK_ORDER_CHECK_EN
  // reference of zero after a terminator can never flag the next key
  logic [DATA_WIDTH-1:0] last_key;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_key    <= '0;
      o_order_err <= 1'b0;
    end else if (push) begin
      last_key <= key;
      if (!is_term && key < last_key) o_order_err <= 1'b1;
    end
  end
`else
  assign o_order_err = 1'b0;
`endif
endmodule

// File: tb/tb_merger_sink.sv
// Directed bench for merger_sink: flow, backpressure, overflow, order check, reset.
module tb_merger_sink;
  import merger_sink_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 8;

`ifdef MERGER_SINK_ORDER_CHECK_EN
  localparam logic ORD = 1'b1;
`else
  localparam logic ORD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        run_done;
  logic [31:0] run_len;
  logic        overflow, order_err;
  logic        m_rdy;
  int          checks = 0;
  int          errors = 0;

  always #5 i_clk = ~i_clk;

  merger_sink_if #(.W(2*DW)) m_if ();
  merger_sink_if #(.W(2*DW)) d_if ();

  merger_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .in_if       (m_if),
    .out_if      (d_if),
    .o_run_done  (run_done),
    .o_run_len   (run_len),
    .o_overflow  (overflow),
    .o_order_err (order_err)
  );

  // merger re-registers ready before using it
  always @(posedge i_clk) m_rdy <= m_if.ready;

  function automatic word_t mkw(input int k);
    key_t kk;
    kk = key_t'(k);
    return {kk ^ key_t'(128'hA5A5), kk};
  endfunction

  task automatic cyc;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic w, input int k);
    m_if.valid = w;
    m_if.data  = mkw(k);
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    drive(1'b0, 0);
    d_if.ready = 1'b0;
    repeat (3) cyc;
    checks++; if (m_if.ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", m_if.ready); end
    checks++; if (d_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", d_if.valid); end
    checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", run_done); end
    checks++; if (run_len !== 32'd0) begin errors++; $display("FAIL rst_len: got %0d want 0", run_len); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL rst_ord: got %b want 0", order_err); end
    i_rst_n = 1'b1;
    cyc;
    checks++; if (m_if.ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", m_if.ready); end
  endtask

  task automatic test_basic;
    int keys [4] = '{5, 7, 9, 0};
    d_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, keys[i]);
      cyc;
      checks++; if (d_if.valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, d_if.valid); end
      checks++; if (d_if.data !== mkw(keys[i])) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, d_if.data, mkw(keys[i])); end
      checks++; if (run_done !== (i == 3)) begin errors++; $display("FAIL basic_done[%0d]: got %b want %b", i, run_done, i == 3); end
    end
    checks++; if (run_len !== 32'd3) begin errors++; $display("FAIL basic_len: got %0d want 3", run_len); end
    drive(1'b0, 0);
    cyc;
    checks++; if (d_if.valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", d_if.valid); end
    checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", run_done); end
    checks++; if (run_len !== 32'd3) begin errors++; $display("FAIL basic_hold: got %0d want 3", run_len); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    d_if.ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(m_rdy, 10 + n);
      if (m_rdy) n++;
      cyc;
    end
    drive(1'b0, 0);
    checks++; if (n !== 7) begin errors++; $display("FAIL bp_accepted: got %0d want 7", n); end
    checks++; if (m_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", m_if.ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b want 0", overflow); end
    d_if.ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (d_if.valid !== 1'b1 || d_if.data !== mkw(10 + i)) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b %h want %h", i, d_if.valid, d_if.data, mkw(10 + i)); end
      cyc;
    end
    checks++; if (d_if.valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", d_if.valid); end
  endtask

  task automatic test_overflow;
    int exp [8] = '{21, 22, 23, 24, 25, 26, 27, 30};
    d_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 20 + i);
      cyc;
    end
    drive(1'b0, 0);
    checks++; if (overflow !== 1'b0 || d_if.data !== mkw(20)) begin errors++; $display("FAIL fill: got ovf=%b %h want ovf=0 %h", overflow, d_if.data, mkw(20)); end
    // full buffer, push and pop in the same cycle
    drive(1'b1, 30);
    d_if.ready = 1'b1;
    cyc;
    drive(1'b0, 0);
    d_if.ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %b want 0", overflow); end
    checks++; if (d_if.data !== mkw(21)) begin errors++; $display("FAIL fullpp_head: got %h want %h", d_if.data, mkw(21)); end
    drive(1'b1, 31);
    cyc;
    drive(1'b0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    d_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (d_if.valid !== 1'b1 || d_if.data !== mkw(exp[i])) begin errors++; $display("FAIL ovf_drain[%0d]: got v=%b %h want %h", i, d_if.valid, d_if.data, mkw(exp[i])); end
      cyc;
    end
    checks++; if (d_if.valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", d_if.valid); end
  endtask

  task automatic test_order;
    int   keys [7] = '{0, 4, 3, 0, 1, 0, 0};
    logic edone[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   elen [7] = '{16, 16, 16, 2, 2, 1, 0};
    d_if.ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, keys[i]);
      cyc;
      checks++; if (run_done !== edone[i]) begin errors++; $display("FAIL ord_done[%0d]: got %b want %b", i, run_done, edone[i]); end
      checks++; if (run_len !== 32'(elen[i])) begin errors++; $display("FAIL ord_len[%0d]: got %0d want %0d", i, run_len, elen[i]); end
      checks++; if (order_err !== ((i >= 2) ? ORD : 1'b0)) begin errors++; $display("FAIL ord_err[%0d]: got %b want %b", i, order_err, (i >= 2) ? ORD : 1'b0); end
    end
    drive(1'b0, 0);
    cyc;
  endtask

  task automatic test_reset_mid_run;
    d_if.ready = 1'b0;
    drive(1'b1, 8);
    cyc;
    drive(1'b1, 9);
    cyc;
    drive(1'b0, 0);
    checks++; if (d_if.valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", d_if.valid); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (d_if.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", d_if.valid); end
    checks++; if (order_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got ord=%b ovf=%b want 0 0", order_err, overflow); end
    for (int i = 0; i < 2; i++) begin
      cyc;
      checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done[%0d]: got %b want 0", i, run_done); end
    end
    i_rst_n = 1'b1;
    cyc;
    d_if.ready = 1'b1;
    drive(1'b1, 6);
    cyc;
    drive(1'b1, 0);
    cyc;
    drive(1'b0, 0);
    checks++; if (run_done !== 1'b1 || run_len !== 32'd1) begin errors++; $display("FAIL mid_run_len: got done=%b len=%0d want 1 1", run_done, run_len); end
    checks++; if (d_if.data !== mkw(0)) begin errors++; $display("FAIL mid_term_data: got %h want %h", d_if.data, mkw(0)); end
    cyc;
    checks++; if (run_done !== 1'b0 || d_if.valid !== 1'b0) begin errors++; $display("FAIL mid_end: got done=%b v=%b want 0 0", run_done, d_if.valid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_order;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
